sd_spi_master: RTL

SD-card SPI master sitting directly downstream of the AVR slave SPI block. It consumes that block's SD interface: lock request, CS_n, start strobe and data byte. It returns the received byte and the lock state. A Z80-side port interface shares the same card. Arbitration is by the AVR lock bit, and ownership changes only between byte transfers.

---
 rtl/sd_spi_master_if.sv | 32 +++
 rtl/sd_spi_master.sv | 107 ++++++++++
 2 files changed

// File: rtl/sd_spi_master_if.sv
// Bundle between the AVR/Z80 requesters and the SD-card SPI master, plus the card pins.
interface sd_spi_master_if;
  logic       avr_lock;
  logic       avr_cs_n;
  logic       avr_start;
  logic [7:0] avr_datain;
  logic [7:0] avr_dataout;
  logic       avr_lock_ack;
  logic       zx_cs_n;
  logic       zx_start;
  logic [7:0] zx_datain;
  logic [7:0] zx_dataout;
  logic       busy;
  logic       sdclk;
  logic       sddo;
  logic       sddi;
  logic       sdcs_n;

  modport slave (
    input  avr_lock, avr_cs_n, avr_start, avr_datain,
    input  zx_cs_n, zx_start, zx_datain, sddi,
    output avr_dataout, avr_lock_ack, zx_dataout,
    output busy, sdclk, sddo, sdcs_n
  );

  modport master (
    output avr_lock, avr_cs_n, avr_start, avr_datain,
    output zx_cs_n, zx_start, zx_datain, sddi,
    input  avr_dataout, avr_lock_ack, zx_dataout,
    input  busy, sdclk, sddo, sdcs_n
  );
endinterface

// File: rtl/sd_spi_master.sv
// SD-card SPI master (mode 0, MSB first) shared by an AVR and a Z80 requester,
// arbitrated by the AVR lock bit with ownership changing only between bytes.
module sd_spi_master #(
  parameter int unsigned HALF = 2
) (
  input logic            fclk,
  input logic            rst_n,
  sd_spi_master_if.slave sd
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] HLAST = 4'(HALF - 1);

  state_t     r_state;
  logic       r_owner;
  logic       r_req;
  logic       r_busy;
  logic       r_sdclk;
  logic       r_sddo;
  logic       r_sdcs_n;
  logic [6:0] r_shift;
  logic [7:0] r_rx;
  logic [7:0] r_avr_dout;
  logic [7:0] r_zx_dout;
  logic [3:0] r_hcnt;
  logic [3:0] r_phase;

  logic       w_lock_change;
  logic       w_start;
  logic [7:0] w_datain;

  always_comb begin
    w_lock_change = (sd.avr_lock != r_owner);
    w_start       = r_owner ? sd.avr_start  : sd.zx_start;
    w_datain      = r_owner ? sd.avr_datain : sd.zx_datain;
  end

  // The shifter holds only the bits not yet on sddo; bit 7 goes straight to sddo on accept.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_sdclk    <= 1'b0;
      r_sddo     <= 1'b1;
      r_sdcs_n   <= 1'b1;
      r_shift    <= '1;
      r_rx       <= '1;
      r_avr_dout <= '1;
      r_zx_dout  <= '1;
      r_hcnt     <= '0;
      r_phase    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sdcs_n <= r_owner ? sd.avr_cs_n : sd.zx_cs_n;
          if (w_lock_change) begin
            r_owner <= sd.avr_lock;
          end else if (w_start) begin
            r_state <= XFER;
            r_busy  <= 1'b1;
            r_shift <= w_datain[6:0];
            r_sddo  <= w_datain[7];
            r_hcnt  <= '0;
            r_phase <= '0;
            r_req   <= r_owner;
          end
        end
        XFER: begin
          if (r_hcnt == HLAST) begin
            r_hcnt  <= '0;
            r_phase <= r_phase + 4'd1;
            if (!r_phase[0]) begin
              r_sdclk <= 1'b1;
              r_rx    <= {r_rx[6:0], sd.sddi};
            end else begin
              r_sdclk <= 1'b0;
              r_shift <= {r_shift[5:0], 1'b1};
              r_sddo  <= r_shift[6];
              if (r_phase == 4'd15) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_sddo  <= 1'b1;
                if (r_req) r_avr_dout <= r_rx;
                else       r_zx_dout  <= r_rx;
              end
            end
          end else begin
            r_hcnt <= r_hcnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sd.avr_dataout  = r_avr_dout;
  assign sd.avr_lock_ack = r_owner;
  assign sd.zx_dataout   = r_zx_dout;
  assign sd.busy         = r_busy;
  assign sd.sdclk        = r_sdclk;
  assign sd.sddo         = r_sddo;
  assign sd.sdcs_n       = r_sdcs_n;

endmodule
